// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART core.
// Holds FSM state encodings, oversampling constants and the parity helper.
package uart_pkg;

    localparam int OVERSAMPLE  = 16;
    localparam int SAMPLE_TICK = 7;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Parity bit that makes the frame even (odd=0) or odd (odd=1).
    function automatic logic parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive buffer holding {ferr, perr, data} words.
// A pop frees a slot in the same cycle, so push+pop on a full FIFO both land.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_txrx_param.sv
// Full-duplex UART with configurable frame, runtime baud divisor,
// 16x oversampled receiver, buffered RX with error flags and loopback.
module uart_txrx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 loop_en,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun
);

    localparam logic [4:0] BIT_LAST  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] STOP_LAST = 5'(STOP_BITS * OVERSAMPLE - 1);
    localparam logic [2:0] DBIT_LAST = 3'(DATA_BITS - 1);
    localparam logic       ODD       = (PARITY_ODD != 0);
    localparam logic       HAS_PAR   = (PARITY_EN != 0);

    // Oversample tick; the divisor is re-latched only on wrap.
    logic [DIV_WIDTH-1:0] tick_cnt;
    logic [DIV_WIDTH-1:0] div_q;
    logic                 tick;

    assign tick = (tick_cnt == div_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            div_q    <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            div_q    <= baud_div;
        end else begin
            tick_cnt <= tick_cnt + DIV_WIDTH'(1);
        end
    end

    tx_state_e            tx_state;
    logic [4:0]           tx_cnt;
    logic [2:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_line;
    logic [4:0]           tx_last;

    assign tx_ready = (tx_state == TX_IDLE);
    assign tx_last  = (tx_state == TX_STOP) ? STOP_LAST : BIT_LAST;
    assign txd      = loop_en ? 1'b1 : tx_line;

    always_comb begin
        tx_line = 1'b1;
        unique case (tx_state)
            TX_START:  tx_line = 1'b0;
            TX_DATA:   tx_line = tx_shift[0];
            TX_PARITY: tx_line = tx_par;
            default:   tx_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else if (tx_state == TX_IDLE) begin
            if (tx_valid) begin
                tx_shift <= tx_data;
                tx_par   <= parity(8'(tx_data), ODD);
                tx_cnt   <= '0;
                tx_state <= TX_START;
            end
        end else if (tick) begin
            if (tx_cnt != tx_last) begin
                tx_cnt <= tx_cnt + 5'd1;
            end else begin
                tx_cnt <= '0;
                unique case (tx_state)
                    TX_START: begin
                        tx_bit   <= '0;
                        tx_state <= TX_DATA;
                    end
                    TX_DATA: begin
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= tx_bit + 3'd1;
                        if (tx_bit == DBIT_LAST) begin
                            tx_state <= HAS_PAR ? TX_PARITY : TX_STOP;
                        end
                    end
                    TX_PARITY: tx_state <= TX_STOP;
                    default:   tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    logic                 sync1;
    logic                 sync2;
    logic                 rx_in;

    assign rx_in = loop_en ? tx_line : rxd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_in;
            sync2 <= sync1;
        end
    end

    rx_state_e            rx_state;
    logic [3:0]           rx_cnt;
    logic [2:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 frame_perr;
    logic                 sample;
    logic                 bit_end;
    logic                 push;
    logic [DATA_BITS+1:0] push_word;

    assign sample    = tick && (rx_cnt == 4'(SAMPLE_TICK));
    assign bit_end   = tick && (rx_cnt == 4'(OVERSAMPLE - 1));
    assign push      = (rx_state == RX_STOP) && sample;
    assign push_word = {~sync2, frame_perr, rx_shift};

    // The detecting tick counts as tick 0 of the start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            frame_perr <= 1'b0;
        end else if (rx_state == RX_IDLE) begin
            if (tick && !sync2) begin
                rx_cnt     <= 4'd1;
                frame_perr <= 1'b0;
                rx_state   <= RX_START;
            end
        end else if (tick) begin
            rx_cnt <= rx_cnt + 4'd1;
            unique case (rx_state)
                RX_START: begin
                    if (sample && sync2) begin
                        rx_state <= RX_IDLE;
                    end else if (bit_end) begin
                        rx_bit   <= '0;
                        rx_state <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (sample) begin
                        rx_shift <= {sync2, rx_shift[DATA_BITS-1:1]};
                    end
                    if (bit_end) begin
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == DBIT_LAST) begin
                            rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
                        end
                    end
                end
                RX_PARITY: begin
                    if (sample) begin
                        frame_perr <= sync2 ^ parity(8'(rx_shift), ODD);
                    end
                    if (bit_end) begin
                        rx_state <= RX_STOP;
                    end
                end
                default: begin
                    if (sample) begin
                        rx_state <= RX_IDLE;
                    end
                end
            endcase
        end
    end

    logic                 fifo_empty;
    logic                 fifo_full;
    logic [DATA_BITS+1:0] fifo_dout;

    uart_rx_fifo #(
        .WIDTH (DATA_BITS + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_word),
        .pop   (rx_ready),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign rx_valid = !fifo_empty;
    assign {rx_ferr, rx_perr, rx_data} = fifo_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= push && fifo_full && !rx_ready;
        end
    end

endmodule
